// File: rtl/pipe_stage_skid.sv
//------------------------------------------------------------------------------
// Module   : pipe_stage_skid
// Purpose  : Generic valid/ready pipeline stage with a 2-entry skid buffer.
//            It has a registered in_ready and zeroes the data of any empty lane.
// Option   : define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt counters
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid #(
  parameter int WIDTH   = 32,
  parameter int NFIELDS = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*NFIELDS-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*NFIELDS-1:0]   out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                bubble_cnt
`endif
);

  localparam int DW = WIDTH * NFIELDS;

  // State encoding is {skid valid, main valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          acc_in, acc_out;

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign out_data  = out_valid ? main_q : '0;
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc_in) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (acc_in && acc_out) begin
            main_d = in_data;
          end else if (acc_in) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (acc_out) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (acc_out) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counters survive flush; only reset clears them. Wrap is natural overflow.
  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, (out_valid & ~out_ready)};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~out_valid};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a 2-deep FIFO model drives a scoreboard queue checked every cycle.
`default_nettype none

module tb_pipe_stage_skid;
  localparam int WIDTH   = 32;
  localparam int NFIELDS = 5;
  localparam int DW      = WIDTH * NFIELDS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
  logic [31:0]   stall_m = '0;
  logic [31:0]   bubble_m = '0;
`endif

  logic [DW-1:0] q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(WIDTH), .NFIELDS(NFIELDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check outputs, then
  // advance the model to reflect the coming rising edge.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic rst);
    logic          exp_v;
    logic          exp_r;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    exp_v = (q.size() > 0);
    exp_r = (q.size() < 2);
    exp_d = exp_v ? q[0] : '0;
    check("out_valid", DW'(out_valid), DW'(exp_v));
    check("in_ready",  DW'(in_ready),  DW'(exp_r));
    check("out_data",  out_data, exp_d);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt",  DW'(stall_cnt),  DW'(stall_m));
    check("bubble_cnt", DW'(bubble_cnt), DW'(bubble_m));
    if (rst) begin
      stall_m  = '0;
      bubble_m = '0;
    end else begin
      if (exp_v && !ordy) stall_m = stall_m + 32'd1;
      if (!exp_v)         bubble_m = bubble_m + 32'd1;
    end
`endif
    if (exp_v && ordy) void'(q.pop_front());
    if (rst || fl) q.delete();
    else if (iv && exp_r) q.push_back(d);
  endtask

  initial begin
    logic [DW-1:0] seq;

    // Reset held two cycles, then idle with reset released.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Streaming k=1..8 at full rate, then drain.
    for (int k = 1; k <= 8; k++) cycle(1'b1, DW'(k), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: 0x11 and 0x22 stack up, then emit in order.
    cycle(1'b1, DW'('h11), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('h22), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('h99), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with 0x33 offered: 0x33 must never appear.
    cycle(1'b1, DW'('h44), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('h55), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('h33), 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset while FULL behaves like flush.
    cycle(1'b1, DW'('h66), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('h77), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DW'('h33), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random handshakes: scoreboard catches loss, duplication and reordering.
    seq = '0;
    for (int i = 0; i < 10000; i++) begin
      seq = seq + 1'b1;
      cycle(1'($urandom_range(0, 1)),
            {$urandom(), $urandom(), $urandom(), $urandom(), seq[31:0]},
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    // 4 empty cycles followed by 3 stall cycles after a fresh reset.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, DW'('h88), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("stall_cnt_3",  DW'(stall_cnt),  DW'(32'd3));
    check("bubble_cnt_4", DW'(bubble_cnt), DW'(32'd4));

    // Wrap: preload all-ones, one stall cycle must bring it to zero.
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    stall_m = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    cycle(1'b1, DW'('haa), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("stall_cnt_wrap", DW'(stall_cnt), DW'(32'd0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
